// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Host-side streaming loader for the CPU program-load handshake. Bytes from
//   an upstream source are buffered in a small FIFO; once started, the loader
//   stages one byte on ui_data per CPU cpu_ready request, counts NUM_BYTES
//   transfers and then waits for the CPU's cpu_done.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               one-cycle load request (IDLE / DONE / ERROR only)
//   in_valid/in_data    upstream byte stream
//   in_ready            FIFO can accept (not full and not in ERROR)
//   cpu_ready           CPU consumes ui_data on every edge it is high
//   cpu_done            CPU load-complete indication
//   programming         high in STREAM and WAIT_DONE (registered)
//   ui_data             staged byte (registered)
//   byte_count          bytes consumed in the current load (saturating)
//   busy                PRIME, STREAM or WAIT_DONE
//   done                sticky load-success flag
//   error               sticky code: 01 underrun, 10 early done, 11 timeout
module cpu_program_loader #(
  parameter int NUM_BYTES    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       cpu_ready,
  input  logic       cpu_done,
  output logic       programming,
  output logic [7:0] ui_data,
  output logic [4:0] byte_count,
  output logic       busy,
  output logic       done,
  output logic [1:0] error
);

  localparam int         AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] NB = 5'(NUM_BYTES);
  localparam logic [7:0] TO = 8'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_STREAM, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  ui_data_q, ui_data_d;
  logic [4:0]  byte_count_q, byte_count_d;
  logic [7:0]  timer_q, timer_d;
  logic        programming_q, programming_d;
  logic        done_q, done_d;
  logic [1:0]  error_q, error_d;

  logic        fifo_empty, fifo_full, push, pop, flush;
  logic [7:0]  head;
  logic [4:0]  cnt_inc;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_ready   = !fifo_full && (state_q != S_ERR);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_q[AW-1:0]];
  assign cnt_inc    = (byte_count_q == NB) ? NB : byte_count_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    ui_data_d    = ui_data_q;
    byte_count_d = byte_count_q;
    timer_d      = timer_q;
    done_d       = done_q;
    error_d      = error_q;
    pop          = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_PRIME;
          byte_count_d = '0;
          done_d       = 1'b0;
          error_d      = 2'b00;
        end
      end
      S_PRIME: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          ui_data_d = head;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        // Early done wins over a same-cycle consume.
        if (cpu_done) begin
          state_d = S_ERR;
          error_d = 2'b10;
        end else if (cpu_ready) begin
          byte_count_d = cnt_inc;
          if (cnt_inc == NB) begin
            state_d = S_WAIT;
            timer_d = '0;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            ui_data_d = head;
          end else begin
            state_d = S_ERR;
            error_d = 2'b01;
          end
        end
      end
      S_WAIT: begin
        if (cpu_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TO) begin
            state_d = S_ERR;
            error_d = 2'b11;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering ERROR discards buffered bytes, including one pushed this edge.
    flush         = (state_d == S_ERR) && (state_q != S_ERR);
    wr_d          = flush ? '0 : wr_q + {{AW{1'b0}}, push};
    rd_d          = flush ? '0 : rd_q + {{AW{1'b0}}, pop};
    programming_d = (state_d == S_STREAM) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_q          <= '0;
      rd_q          <= '0;
      ui_data_q     <= '0;
      byte_count_q  <= '0;
      timer_q       <= '0;
      programming_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      ui_data_q     <= ui_data_d;
      byte_count_q  <= byte_count_d;
      timer_q       <= timer_d;
      programming_q <= programming_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_data;
  end

  assign programming = programming_q;
  assign ui_data     = ui_data_q;
  assign byte_count  = byte_count_q;
  assign busy        = (state_q == S_PRIME) || (state_q == S_STREAM) || (state_q == S_WAIT);
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: directed load scenarios with random payloads.
// The byte stream is modelled as an ordered queue: every byte the FIFO
// accepts is appended, and each CPU consume must see the oldest one.
module tb_cpu_program_loader;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic       cpu_ready = 1'b0, cpu_done = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, programming, busy, done;
  logic [7:0] ui_data;
  logic [4:0] byte_count;
  logic [1:0] error;

  cpu_program_loader #(.NUM_BYTES(16), .FIFO_DEPTH(4), .DONE_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .programming(programming), .ui_data(ui_data),
    .byte_count(byte_count), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] pend[$];   // bytes waiting to be offered upstream
  logic [7:0] sent[$];   // bytes accepted and not yet consumed by the CPU

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    chk("push_ready", in_ready, 1);
    if (in_ready) sent.push_back(b);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pend.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Feed pending bytes whenever accepted; raise cpu_ready every `period`
  // cycles while programming; check each consumed byte and the running count.
  task automatic stream(input int period, input int nbytes, output int ncyc);
    int         consumed = 0;
    logic [8:0] want;
    ncyc = 0;
    while (consumed < nbytes && ncyc < 2000) begin
      in_valid  = (pend.size() > 0);
      in_data   = (pend.size() > 0) ? pend[0] : 8'h00;
      cpu_ready = programming && ((ncyc % period) == period - 1);
      if (cpu_ready) begin
        want = (sent.size() > 0) ? {1'b0, sent.pop_front()} : 9'h1FF;
        chk("consume_data", {1'b0, ui_data}, want);
        consumed++;
      end
      if (in_valid && in_ready) sent.push_back(pend.pop_front());
      cyc();
      ncyc++;
      if (cpu_ready) chk("byte_count", byte_count, consumed);
    end
    cpu_ready = 1'b0;
    in_valid  = 1'b0;
    chk("stream_complete", consumed, nbytes);
  endtask

  initial begin
    int n;
    // Reset state
    #3;
    chk("rst_programming", programming, 0);
    chk("rst_ui_data", ui_data, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Nominal: pre-fill 0x10..0x13, start, stream 0x14..0x1F, ready every 3
    for (int i = 0; i < 4; i++) push_one(8'(8'h10 + i));
    for (int i = 4; i < 16; i++) pend.push_back(8'(8'h10 + i));
    pulse_start();
    chk("nom_prime_busy", busy, 1);
    chk("nom_prime_prog", programming, 0);
    cyc();
    chk("nom_stream_prog", programming, 1);
    chk("nom_first_byte", ui_data, 8'h10);
    stream(3, 16, n);
    cyc();
    cpu_done = 1'b1;
    cyc();
    cpu_done = 1'b0;
    chk("nom_done", done, 1);
    chk("nom_prog", programming, 0);
    chk("nom_count", byte_count, 16);
    chk("nom_error", error, 0);
    chk("nom_busy", busy, 0);

    // Back-to-back: FIFO full at start, cpu_ready held high
    for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)));
    chk("b2b_full", in_ready, 0);
    fill_random(12);
    pulse_start();
    cyc();
    chk("b2b_prog", programming, 1);
    stream(1, 16, n);
    chk("b2b_cycles", n, 16);
    chk("b2b_no_error", error, 0);
    cpu_done = 1'b1;
    cyc();
    cpu_done = 1'b0;
    chk("b2b_done", done, 1);

    // Underrun: two bytes only
    for (int i = 0; i < 2; i++) push_one(8'($urandom_range(0, 255)));
    pulse_start();
    cyc();
    stream(2, 2, n);
    chk("ur_error", error, 2'b01);
    chk("ur_prog", programming, 0);
    chk("ur_in_ready", in_ready, 0);
    chk("ur_count", byte_count, 2);
    cpu_ready = 1'b1;
    cyc();
    cpu_ready = 1'b0;
    chk("ur_error_held", error, 2'b01);
    chk("ur_count_held", byte_count, 2);

    // Early done after 5 bytes; FIFO was flushed so restart from empty
    pulse_start();
    chk("ed_cleared", error, 0);
    chk("ed_prime_busy", busy, 1);
    fill_random(8);
    stream(2, 5, n);
    cpu_done = 1'b1;
    cyc();
    cpu_done = 1'b0;
    chk("ed_error", error, 2'b10);
    chk("ed_count", byte_count, 5);
    chk("ed_prog", programming, 0);
    sent.delete();
    pend.delete();
    pulse_start();
    chk("ed_restart_error", error, 0);
    chk("ed_restart_busy", busy, 1);
    chk("ed_restart_prog", programming, 0);

    // Timeout: cpu_done never arrives; cpu_ready ignored in WAIT_DONE
    fill_random(16);
    stream(2, 16, n);
    chk("to_wait_prog", programming, 1);
    cpu_ready = 1'b1;
    repeat (254) cyc();
    chk("to_not_yet", error, 0);
    chk("to_busy", busy, 1);
    cyc();
    cpu_ready = 1'b0;
    chk("to_error", error, 2'b11);
    chk("to_prog", programming, 0);
    chk("to_count", byte_count, 16);

    // Reset in the middle of STREAM at byte 7
    pulse_start();
    fill_random(16);
    stream(2, 7, n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_prog", programming, 0);
    chk("mr_count", byte_count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_ui_data", ui_data, 0);
    chk("mr_error", error, 0);
    chk("mr_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sent.delete();
    pend.delete();
    cyc();
    fill_random(16);
    pulse_start();
    stream(3, 16, n);
    cpu_done = 1'b1;
    cyc();
    cpu_done = 1'b0;
    chk("reload_done", done, 1);
    chk("reload_error", error, 0);
    chk("reload_count", byte_count, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
